// File: rtl/updn_counter_p.sv
// Parametrised loadable up/down counter with runtime limit, step,
// wrap/saturate policy, sticky ovf/unf, wrap and load_err pulses.
//
// Ports:
//   clk, rst (async, active-low)
//   load, data      : load min(data, limit); load_err if data > limit
//   en, mode, sat   : count enable, 1=up/0=down, 1=saturate/0=wrap
//   limit, step     : inclusive upper bound, count step (1..limit+1)
//   clr_flags       : clears ovf/unf (a same-cycle set wins)
//   data_out        : registered count
//   tc              : terminal count for the current direction
//   wrap, load_err  : one-cycle registered pulses
//   ovf, unf        : sticky registered over/underflow flags
module updn_counter_p #(
  parameter int unsigned          WIDTH   = 32,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             unf,
  output logic             load_err
);

  localparam int unsigned W = WIDTH;

  // All range arithmetic is done in W+1 bits so that
  // limit = 2^W-1 (limit+1 = 2^W) needs no special case.
  logic [W:0]   lim_x;
  logic [W:0]   lim1;
  logic [W:0]   sum;
  logic [W:0]   up_wr;
  logic [W:0]   dn_wr;

  logic         over;
  logic         do_ld;
  logic         do_cl;
  logic         do_up;
  logic         do_dn;

  logic [W-1:0] q_n;
  logic         wrap_n;
  logic         lerr_n;
  logic         ovf_set;
  logic         unf_set;

  assign lim_x = {1'b0, limit};
  assign lim1  = lim_x + {{W{1'b0}}, 1'b1};
  assign sum   = {1'b0, data_out} + {1'b0, step};
  assign up_wr = sum - lim1;
  assign dn_wr = {1'b0, data_out} + lim1 - {1'b0, step};

  // Limit lowered below the current count: clamp first.
  assign over  = data_out > limit;

  assign do_ld = load;
  assign do_cl = !load && en && over;
  assign do_up = !load && en && !over && mode;
  assign do_dn = !load && en && !over && !mode;

  always_comb begin
    q_n     = data_out;
    wrap_n  = 1'b0;
    lerr_n  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      do_ld: begin
        if (data > limit) begin
          q_n    = limit;
          lerr_n = 1'b1;
        end else begin
          q_n = data;
        end
      end
      do_cl: begin
        q_n = limit;
      end
      do_up: begin
        if (sum <= lim_x) begin
          q_n = sum[W-1:0];
        end else begin
          ovf_set = 1'b1;
          if (sat) begin
            q_n = limit;
          end else begin
            q_n    = up_wr[W-1:0];
            wrap_n = 1'b1;
          end
        end
      end
      do_dn: begin
        if (data_out >= step) begin
          q_n = data_out - step;
        end else begin
          unf_set = 1'b1;
          if (sat) begin
            q_n = '0;
          end else begin
            q_n    = dn_wr[W-1:0];
            wrap_n = 1'b1;
          end
        end
      end
      default: begin
        q_n = data_out;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= RST_VAL;
      wrap     <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data_out <= q_n;
      wrap     <= wrap_n;
      load_err <= lerr_n;
      ovf      <= (ovf & ~clr_flags) | ovf_set;
      unf      <= (unf & ~clr_flags) | unf_set;
    end
  end

  assign tc = mode ? (data_out == limit)
                   : (data_out == '0);

endmodule

// File: doc/updn_counter_p.md
# updn_counter_p

Parametrised up/down counter that generalises the team's 32-bit loadable up/down counter. It adds width and reset-value parameters, a runtime inclusive upper limit, a programmable step, and a selectable wrap or saturate policy. Sticky overflow and underflow flags, a wrap pulse and a terminal-count flag are provided for the surrounding control logic and for the scoreboard in the verification environment.

## Interface
Parameters:
- WIDTH, 32, counter, data, limit and step width (≥ 2)
- RST_VAL, 0, value of data_out after reset (must be ≤ every limit used)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset; asserting it clears state immediately, deassertion is synchronised externally
- load  in  1  synchronous load of data
- en  in  1  count enable
- mode  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at bounds, 0 = wrap modulo limit+1
- data  in  WIDTH  load value
- limit  in  WIDTH  inclusive upper bound of the count range [0, limit]
- step  in  WIDTH  increment/decrement amount, legal range 1..limit+1
- clr_flags  in  1  clears ovf/unf
- data_out  out  WIDTH  registered count
- tc  out  1  combinational: (mode=1 and data_out==limit) or (mode=0 and data_out==0)
- wrap  out  1  registered one-cycle pulse on a wrap event
- ovf  out  1  sticky, registered: an up-count crossed limit
- unf  out  1  sticky, registered: a down-count crossed 0
- load_err  out  1  registered one-cycle pulse: loaded data exceeded limit

## Operation
- Priority per cycle: rst > load > en > hold.
- load=1: data_out ← min(data, limit). load_err=1 if data > limit. wrap=0 and ovf/unf are unchanged, regardless of en.
- en=1, load=0, data_out > limit (limit lowered at runtime): data_out ← limit. No flags and no wrap.
- Up count (mode=1), sum computed in WIDTH+1 bits, s = data_out + step:
  - s ≤ limit: data_out ← s.
  - s > limit, sat=1: data_out ← limit, ovf←1.
  - s > limit, sat=0: data_out ← s − (limit+1), ovf←1, wrap=1.
- Down count (mode=0):
  - data_out ≥ step: data_out ← data_out − step.
  - Otherwise with sat=1: data_out ← 0, unf←1.
  - Otherwise with sat=0: data_out ← data_out + (limit+1) − step in WIDTH+1 bits, unf←1, wrap=1.
- limit = 2^WIDTH−1: limit+1 uses the carry bit. Wrap is then plain modulo 2^WIDTH.
- Saturated hold at a bound with en=1: ovf/unf are re-set every cycle and wrap stays 0.
- clr_flags=1 clears ovf/unf. If a set event occurs in the same cycle, set wins (flag ends at 1).
- step=0 or step > limit+1 is illegal. Behaviour is undefined, and the assertion in the bench flags it.
- mode, sat, limit and step may change on any cycle. Each takes effect on the next clock edge.

## Timing
- Reset (rst=0): data_out=RST_VAL, wrap=0, ovf=0, unf=0, load_err=0. This holds asynchronously, including mid-count. The first update occurs on the first posedge with rst=1.
- Load and count latency is 1 cycle: inputs sampled at edge N appear on data_out after edge N.
- wrap and load_err are high for exactly the cycle following the triggering edge, then return to 0 unless retriggered.
- tc follows data_out and mode combinationally, with no added latency.
- Stimulus is driven off-edge via the driver clocking block, consistent with existing counter benches.

## Test plan
- Reset mid-count: WIDTH=8, RST_VAL=5, count up to 40, assert rst between edges -> data_out=5 and all flags 0 immediately, held until release.
- Up wrap: limit=9, step=3, sat=0, load 7 then en -> sequence 7, 0 (wrap=1, ovf=1), 3, 6, 9 (tc=1), 2 (wrap=1).
- Down saturate: limit=200, step=50, sat=1, mode=0, load 120 -> 70, 20, 0 (unf=1), 0 (unf stays 1, wrap=0). clr_flags with en=0 -> unf=0.
- Load clamp and priority: limit=100, load=1, en=1, data=250 -> data_out=100, load_err pulse, no count that cycle. Then limit=30 with en=1 -> data_out=30, no flags.
- Full-range wrap: WIDTH=32, limit=0xFFFFFFFF, step=1, mode=0 from 0 -> 0xFFFFFFFF, wrap=1, unf=1. Then mode=1 -> 0, wrap=1, ovf=1.
- Flag set/clear collision: clr_flags=1 on the same edge as an overflow -> ovf=1 after the edge.
